// File: rtl/multi_cycle_control.sv
// Multi-cycle LEGv8 control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for R-type, LDUR, STUR and CBZ.
// Latency: R-type 4 cycles, LDUR 4+MEM_WAIT, STUR 3+MEM_WAIT, CBZ 3; instr_done marks the final cycle.
// Backpressure: none; memory wait is a fixed MEM_WAIT-cycle hold, and pc_reset aborts any instruction at once.
//
// Ports:
//   clk, pc_reset        - clock and synchronous active-high reset
//   opcode[10:0]         - instruction[31:21]; sampled only in DECODE
//   zero_alu             - ALU zero flag; used only in a CBZ EXECUTE cycle
//   ir_write .. reg_write, alu_op[1:0] - datapath strobes and mux selects
//   instr_done           - one-cycle pulse in an instruction's final cycle
//   illegal, state[2:0]  - HALT indication and current FSM encoding
//
// Build option: define CPU_ILLEGAL_TRAP_EN to make an illegal opcode park
// the FSM in HALT until reset; otherwise an illegal opcode executes as a NOP.

module multi_cycle_control #(
    parameter int unsigned MEM_WAIT = 1     // data-memory cycles, 1..15
) (
    input  logic        clk,
    input  logic        pc_reset,
    input  logic [10:0] opcode,
    input  logic        zero_alu,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_to_loc,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE    = 3'd0,
        C_RTYPE   = 3'd1,
        C_LDUR    = 3'd2,
        C_STUR    = 3'd3,
        C_CBZ     = 3'd4,
        C_ILLEGAL = 3'd5
    } iclass_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    iclass_t    class_q, class_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_last;

    function automatic iclass_t decode_op(input logic [10:0] op);
        iclass_t c;
        casez (op)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: c = C_RTYPE;
            11'b11111000010: c = C_LDUR;
            11'b11111000000: c = C_STUR;
            11'b10110100???: c = C_CBZ;
            default:         c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    assign mem_last = (cnt_q == LAST_CNT);
    assign state    = state_q;

    // State register, instruction class and memory wait counter
    always_ff @(posedge clk) begin
        if (pc_reset) begin
            state_q <= S_FETCH;
            class_q <= C_NONE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the class is latched once in DECODE so later opcode
    // changes (the IR may be reloaded) cannot disturb the instruction.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                class_d = decode_op(opcode);
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (class_q)
                    C_RTYPE: state_d = S_WRITEBACK;
                    C_LDUR,
                    C_STUR: begin
                        state_d = S_MEMORY;
                        cnt_d   = 4'd0;
                    end
                    C_CBZ:   state_d = S_FETCH;
                    default: begin
`ifdef CPU_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMORY: begin
                if (mem_last) begin
                    state_d = (class_q == C_LDUR) ? S_WRITEBACK : S_FETCH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;   // unused codes 6/7 recover
        endcase
    end

    // Output decode. Outputs are forced low while pc_reset is high so an
    // aborted instruction cannot issue a write in the reset cycle.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_to_loc = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!pc_reset) begin
            case (state_q)
                S_FETCH: ir_write = 1'b1;
                S_EXECUTE: begin
                    case (class_q)
                        C_RTYPE: alu_op = 2'b10;
                        C_LDUR:  alu_src = 1'b1;
                        C_STUR: begin
                            alu_src    = 1'b1;
                            reg_to_loc = 1'b1;
                        end
                        C_CBZ: begin
                            alu_op     = 2'b01;
                            reg_to_loc = 1'b1;
                            pc_src     = zero_alu;
                            pc_write   = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: begin
`ifdef CPU_ILLEGAL_TRAP_EN
                            pc_write   = 1'b0;
`else
                            pc_write   = 1'b1;
                            instr_done = 1'b1;
`endif
                        end
                    endcase
                end
                S_MEMORY: begin
                    mem_read  = (class_q == C_LDUR);
                    mem_write = (class_q == C_STUR);
                    // STUR retires in its last memory cycle
                    if (class_q == C_STUR && mem_last) begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (class_q == C_LDUR);
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                S_HALT:  illegal = 1'b1;
                default: illegal = 1'b0;
            endcase
        end
    end

endmodule
